// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   Word-organised data RAM for the load/store stage. Supports byte, half and
//   word accesses on little-endian byte lanes, sign/zero extension of loads,
//   and an error flag for misaligned, out-of-range or illegal-size requests.
//   A request/response handshake with WAIT_STATES extra access cycles lets
//   the pipeline stall on slow memory.
//
// Ports
//   clk           clock, all state on posedge
//   rst           synchronous active-high reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle (IDLE or RESP)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load result; 0 for stores and errors
//   rsp_err       misaligned, out of range or illegal size
module data_memory_bytelane #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wait_cnt;

  logic              we_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              last_wait;
  logic              commit;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wlanes;

  // Error when the size is illegal, the access is misaligned for its size,
  // or any address bit above the word-index field is set.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [ADDR_W-1:0] addr);
    logic hi;
    logic e;
    hi = |(addr >> (IDX_W + 2));
    case (size)
      2'b00:   e = hi;
      2'b01:   e = hi | addr[0];
      2'b10:   e = hi | (addr[1:0] != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] ln);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << ln;
      2'b01:   m = ln[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned store data onto every lane so the byte
  // enables alone pick which bytes land in the word.
  function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  ln,
                                              input logic        uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = word >> {ln, 3'b000};
    b  = signed'(sh[7:0]);
    h  = signed'(sh[15:0]);
    case (size)
      2'b00:   r = uns ? {24'h0, sh[7:0]}  : 32'(b);
      2'b01:   r = uns ? {16'h0, sh[15:0]} : 32'(h);
      2'b10:   r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  assign accept    = req_valid & req_ready;
  assign last_wait = (wait_cnt == 4'(WAIT_STATES));
  assign commit    = (state == ACCESS) && last_wait;
  assign acc_err   = access_err(size_p0, addr_p0);
  assign idx       = addr_p0[IDX_W+1:2];
  assign lane      = addr_p0[1:0];
  assign be        = store_be(size_p0, lane);
  assign wlanes    = store_lanes(size_p0, wdata_p0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (last_wait) state_nxt = RESP;
      RESP:    state_nxt = accept ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) || (state == RESP);
    rsp_valid = (state == RESP);
  end

  // p0: request fields captured on accept and held through ACCESS
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept)
        wait_cnt <= 4'd0;
      else if ((state == ACCESS) && !last_wait)
        wait_cnt <= wait_cnt + 4'd1;
      // Commit edge: the response is captured here and shown during RESP.
      if (commit) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || we_p0) ? 32'h0
                   : load_extend(mem[idx], size_p0, lane, uns_p0);
      end
    end
  end

  // Reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && !rst && we_p0 && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // WS=0 instance
  logic        rst0, req_valid0, req_ready0, req_we0, req_unsigned0;
  logic [1:0]  req_size0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic        rsp_valid0, rsp_err0;

  // WS=3 instance
  logic        rst3, req_valid3, req_ready3, req_we3, req_unsigned3;
  logic [1:0]  req_size3;
  logic [31:0] req_addr3, req_wdata3, rsp_rdata3;
  logic        rsp_valid3, rsp_err3;

  data_memory_bytelane #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_size(req_size0), .req_unsigned(req_unsigned0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  data_memory_bytelane #(.DEPTH(1024), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_size(req_size3), .req_unsigned(req_unsigned3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on the WS=0 instance; checks ready, latency and response.
  task automatic txn0(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    int n;
    @(negedge clk);
    chk({tag, ".ready"}, {31'h0, req_ready0}, 32'h1);
    req_valid0 = 1'b1; req_we0 = we; req_size0 = size; req_unsigned0 = uns;
    req_addr0 = addr; req_wdata0 = wdata;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid0 && n < 20);
    chk({tag, ".lat"},   n,                      32'd2);
    chk({tag, ".rdata"}, rsp_rdata0,             exp_rdata);
    chk({tag, ".err"},   {31'h0, rsp_err0},      {31'h0, exp_err});
  endtask

  // Fields for the WS=3 back-to-back sequence.
  logic        b_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  b_size [4] = '{2'b10, 2'b10, 2'b00, 2'b10};
  logic [31:0] b_addr [4] = '{32'h40, 32'h40, 32'h43, 32'h40};
  logic [31:0] b_wd   [4] = '{32'hCAFEF00D, 32'h0, 32'h000000AA, 32'h0};
  logic [31:0] b_exp  [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hAAFEF00D};

  initial begin
    rst0 = 1'b1; req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 2'b00;
    req_unsigned0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
    rst3 = 1'b1; req_valid3 = 1'b0; req_we3 = 1'b0; req_size3 = 2'b00;
    req_unsigned3 = 1'b0; req_addr3 = 32'h0; req_wdata3 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;

    // Reset state
    chk("rst.ready", {31'h0, req_ready0}, 32'h1);
    chk("rst.valid", {31'h0, rsp_valid0}, 32'h0);
    chk("rst.rdata", rsp_rdata0,          32'h0);
    chk("rst.err",   {31'h0, rsp_err0},   32'h0);

    // Word store/load
    txn0("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    txn0("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    // Byte lanes (upper wdata bits must be ignored)
    txn0("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, 32'h0,        1'b0);
    txn0("lb11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0);
    txn0("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h00000080, 1'b0);
    txn0("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0);
    // Halves
    txn0("sh12",  1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        1'b0);
    txn0("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00001234, 1'b0);
    txn0("sh12b", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0,        1'b0);
    txn0("lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0);
    txn0("lh12b", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0);
    txn0("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h800180EF, 1'b0);
    txn0("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0);
    txn0("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    txn0("lh10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFF80EF, 1'b0);
    // Errors
    txn0("elw13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1);
    txn0("elh11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1);
    txn0("esz3",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1);
    txn0("esh11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 32'h0,        1'b1);
    txn0("lw10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h800180EF, 1'b0);
    txn0("sw0",   1'b1, 2'b10, 1'b0, 32'h0,  32'hA5A5A5A5, 32'h0,        1'b0);
    txn0("eswhi", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, 32'h0,      1'b1);
    txn0("lw0",   1'b0, 2'b10, 1'b0, 32'h0,  32'h0,        32'hA5A5A5A5, 1'b0);

    // Reset during ACCESS drops the store
    txn0("sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0,        1'b0);
    @(negedge clk);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_size0 = 2'b10; req_unsigned0 = 1'b0;
    req_addr0 = 32'h20; req_wdata0 = 32'h00000055;
    @(posedge clk);
    #1 req_valid0 = 1'b0; rst0 = 1'b1;
    @(negedge clk);
    chk("rstmid.acc", {31'h0, rsp_valid0}, 32'h0);
    @(negedge clk);
    chk("rstmid.v1",  {31'h0, rsp_valid0}, 32'h0);
    rst0 = 1'b0;
    @(negedge clk);
    chk("rstmid.v2",  {31'h0, rsp_valid0}, 32'h0);
    txn0("lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h11223344, 1'b0);

    // WS=3 back-to-back with req_valid held
    @(negedge clk);
    req_valid3 = 1'b1;
    req_we3 = b_we[0]; req_size3 = b_size[0]; req_addr3 = b_addr[0]; req_wdata3 = b_wd[0];
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b%0d.ready", i), {31'h0, req_ready3}, 32'h1);
      @(posedge clk);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk($sformatf("b2b%0d.busy%0d", i, j), {30'h0, req_ready3, rsp_valid3}, 32'h0);
      end
      @(negedge clk);
      chk($sformatf("b2b%0d.valid", i), {31'h0, rsp_valid3}, 32'h1);
      chk($sformatf("b2b%0d.rdata", i), rsp_rdata3,          b_exp[i]);
      chk($sformatf("b2b%0d.err", i),   {31'h0, rsp_err3},   32'h0);
      if (i < 3) begin
        req_we3 = b_we[i+1]; req_size3 = b_size[i+1];
        req_addr3 = b_addr[i+1]; req_wdata3 = b_wd[i+1];
      end else begin
        req_valid3 = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b.idle", {30'h0, req_ready3, rsp_valid3}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
